sb_tx_msg_arbiter: RTL

Shares the sideband TX message path between two requesters: the LTSM training sequencer and the RDI/adapter message source. Each message is accepted through a req/gnt handshake, its fields are registered, and it is launched into the sideband TX wrapper as a single `msg_valid` pulse. The block then tracks the wrapper's `busy` flag through one full transaction and reports completion or timeout to the requester that owns it. Arbitration is round-robin, and launches are held off while a start-pattern sequence is in progress.

---
 rtl/sb_tx_msg_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sb_tx_msg_arbiter.sv
// Round-robin arbiter sharing the sideband TX message path between the LTSM
// sequencer and the RDI message source; tracks TX busy and reports done/timeout.
module sb_tx_msg_arbiter #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pattern_active,
  input  logic        i_tx_busy,
  input  logic        i_ltsm_req,
  input  logic [3:0]  i_ltsm_state,
  input  logic [3:0]  i_ltsm_sub_state,
  input  logic [3:0]  i_ltsm_msg_no,
  input  logic [2:0]  i_ltsm_msg_info,
  input  logic        i_ltsm_data_valid,
  input  logic [15:0] i_ltsm_data_bus,
  input  logic        i_rdi_req,
  input  logic [1:0]  i_rdi_msg_code,
  input  logic [3:0]  i_rdi_msg_sub_code,
  input  logic [1:0]  i_rdi_msg_info,
  output logic        o_ltsm_gnt,
  output logic        o_rdi_gnt,
  output logic        o_ltsm_done,
  output logic        o_rdi_done,
  output logic        o_timeout,
  output logic        o_msg_valid,
  output logic        o_data_valid,
  output logic        o_rdi_msg,
  output logic [3:0]  o_state,
  output logic [3:0]  o_sub_state,
  output logic [3:0]  o_msg_no,
  output logic [2:0]  o_msg_info,
  output logic [15:0] o_data_bus,
  output logic [1:0]  o_rdi_msg_code,
  output logic [3:0]  o_rdi_msg_sub_code,
  output logic [1:0]  o_rdi_msg_info
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             last_rdi_reg, last_rdi_next;

  logic msg_valid_reg, msg_valid_next;
  logic ltsm_gnt_reg, ltsm_gnt_next;
  logic rdi_gnt_reg, rdi_gnt_next;
  logic ltsm_done_reg, ltsm_done_next;
  logic rdi_done_reg, rdi_done_next;
  logic timeout_reg, timeout_next;
  logic rdi_msg_reg, rdi_msg_next;
  logic data_valid_reg, data_valid_next;

  logic [3:0]  ltsm_state_reg, ltsm_state_next;
  logic [3:0]  ltsm_sub_state_reg, ltsm_sub_state_next;
  logic [3:0]  ltsm_msg_no_reg, ltsm_msg_no_next;
  logic [2:0]  ltsm_msg_info_reg, ltsm_msg_info_next;
  logic [15:0] ltsm_data_bus_reg, ltsm_data_bus_next;
  logic [1:0]  rdi_code_reg, rdi_code_next;
  logic [3:0]  rdi_sub_code_reg, rdi_sub_code_next;
  logic [1:0]  rdi_info_reg, rdi_info_next;

  logic launch_ok;
  logic pick_rdi;

  assign launch_ok = !i_pattern_active && !i_tx_busy && (i_ltsm_req || i_rdi_req);
  // On a tie the requester not granted last wins.
  assign pick_rdi  = i_rdi_req && (!i_ltsm_req || !last_rdi_reg);
  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg          <= IDLE;
      cnt_reg            <= '0;
      last_rdi_reg       <= 1'b1;
      msg_valid_reg      <= 1'b0;
      ltsm_gnt_reg       <= 1'b0;
      rdi_gnt_reg        <= 1'b0;
      ltsm_done_reg      <= 1'b0;
      rdi_done_reg       <= 1'b0;
      timeout_reg        <= 1'b0;
      rdi_msg_reg        <= 1'b0;
      data_valid_reg     <= 1'b0;
      ltsm_state_reg     <= '0;
      ltsm_sub_state_reg <= '0;
      ltsm_msg_no_reg    <= '0;
      ltsm_msg_info_reg  <= '0;
      ltsm_data_bus_reg  <= '0;
      rdi_code_reg       <= '0;
      rdi_sub_code_reg   <= '0;
      rdi_info_reg       <= '0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      last_rdi_reg       <= last_rdi_next;
      msg_valid_reg      <= msg_valid_next;
      ltsm_gnt_reg       <= ltsm_gnt_next;
      rdi_gnt_reg        <= rdi_gnt_next;
      ltsm_done_reg      <= ltsm_done_next;
      rdi_done_reg       <= rdi_done_next;
      timeout_reg        <= timeout_next;
      rdi_msg_reg        <= rdi_msg_next;
      data_valid_reg     <= data_valid_next;
      ltsm_state_reg     <= ltsm_state_next;
      ltsm_sub_state_reg <= ltsm_sub_state_next;
      ltsm_msg_no_reg    <= ltsm_msg_no_next;
      ltsm_msg_info_reg  <= ltsm_msg_info_next;
      ltsm_data_bus_reg  <= ltsm_data_bus_next;
      rdi_code_reg       <= rdi_code_next;
      rdi_sub_code_reg   <= rdi_sub_code_next;
      rdi_info_reg       <= rdi_info_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    cnt_next            = cnt_reg;
    last_rdi_next       = last_rdi_reg;
    msg_valid_next      = 1'b0;
    ltsm_gnt_next       = 1'b0;
    rdi_gnt_next        = 1'b0;
    ltsm_done_next      = 1'b0;
    rdi_done_next       = 1'b0;
    timeout_next        = 1'b0;
    rdi_msg_next        = rdi_msg_reg;
    data_valid_next     = data_valid_reg;
    ltsm_state_next     = ltsm_state_reg;
    ltsm_sub_state_next = ltsm_sub_state_reg;
    ltsm_msg_no_next    = ltsm_msg_no_reg;
    ltsm_msg_info_next  = ltsm_msg_info_reg;
    ltsm_data_bus_next  = ltsm_data_bus_reg;
    rdi_code_next       = rdi_code_reg;
    rdi_sub_code_next   = rdi_sub_code_reg;
    rdi_info_next       = rdi_info_reg;

    case (state_reg)
      IDLE: begin
        if (launch_ok) begin
          state_next     = LAUNCH;
          msg_valid_next = 1'b1;
          ltsm_gnt_next  = !pick_rdi;
          rdi_gnt_next   = pick_rdi;
          rdi_msg_next   = pick_rdi;
          // The losing side's field outputs are forced to zero.
          data_valid_next     = pick_rdi ? 1'b0  : i_ltsm_data_valid;
          ltsm_state_next     = pick_rdi ? 4'd0  : i_ltsm_state;
          ltsm_sub_state_next = pick_rdi ? 4'd0  : i_ltsm_sub_state;
          ltsm_msg_no_next    = pick_rdi ? 4'd0  : i_ltsm_msg_no;
          ltsm_msg_info_next  = pick_rdi ? 3'd0  : i_ltsm_msg_info;
          ltsm_data_bus_next  = pick_rdi ? 16'd0 : i_ltsm_data_bus;
          rdi_code_next       = pick_rdi ? i_rdi_msg_code     : 2'd0;
          rdi_sub_code_next   = pick_rdi ? i_rdi_msg_sub_code : 4'd0;
          rdi_info_next       = pick_rdi ? i_rdi_msg_info     : 2'd0;
        end
      end
      LAUNCH: begin
        state_next    = WAIT_BUSY;
        cnt_next      = '0;
        last_rdi_next = rdi_msg_reg;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_next = WAIT_DONE;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc >= CNT_LAST) begin
            state_next     = IDLE;
            timeout_next   = 1'b1;
            ltsm_done_next = !rdi_msg_reg;
            rdi_done_next  = rdi_msg_reg;
          end
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_next     = IDLE;
          ltsm_done_next = !rdi_msg_reg;
          rdi_done_next  = rdi_msg_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_ltsm_gnt         = ltsm_gnt_reg;
  assign o_rdi_gnt          = rdi_gnt_reg;
  assign o_ltsm_done        = ltsm_done_reg;
  assign o_rdi_done         = rdi_done_reg;
  assign o_timeout          = timeout_reg;
  assign o_msg_valid        = msg_valid_reg;
  assign o_data_valid       = data_valid_reg;
  assign o_rdi_msg          = rdi_msg_reg;
  assign o_state            = ltsm_state_reg;
  assign o_sub_state        = ltsm_sub_state_reg;
  assign o_msg_no           = ltsm_msg_no_reg;
  assign o_msg_info         = ltsm_msg_info_reg;
  assign o_data_bus         = ltsm_data_bus_reg;
  assign o_rdi_msg_code     = rdi_code_reg;
  assign o_rdi_msg_sub_code = rdi_sub_code_reg;
  assign o_rdi_msg_info     = rdi_info_reg;

endmodule
